// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: word type, reset PC default
// and the fetch FSM state encoding.
package fetch_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_next.sv
// pc_next: combinational next-PC computation for the fetch stage.
// Ports:
//   pc            current program counter
//   pc_src        take branch
//   branch_offset sign-extended word offset from decode
//   pc_inc_2      pc + 2 (16-bit modulo)
//   pc_nxt        pc_inc_2, or pc_inc_2 + byte offset when pc_src is set
module pc_next
  import fetch_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic              pc_src,
  input  logic [WORD_W-1:0] branch_offset,
  output logic [WORD_W-1:0] pc_inc_2,
  output logic [WORD_W-1:0] pc_nxt
);

  logic [WORD_W-1:0] offset_bytes;

  // Word offset to byte offset; bit 15 is a sign copy and drops out of the shift.
  always_comb begin
    pc_inc_2     = pc + WORD_W'(2);
    offset_bytes = {branch_offset[WORD_W-2:0], 1'b0};
    pc_nxt       = pc_src ? (pc_inc_2 + offset_bytes) : pc_inc_2;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches one 16-bit word per instruction over a
// request/response memory port and presents it to decode for one cycle.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   PCSrc, branch_offset, hlt       decode feedback, used only in EXEC
//   imem_req/addr/ready             request channel (addr = pc)
//   imem_rvalid/rdata               response channel, captured only in WAIT
//   instr, pc_inc_2, instr_valid    instruction presented to decode
//   pc, halted, retired             status
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCSrc,
  input  logic [15:0]      branch_offset,
  input  logic             hlt,
  output logic             imem_req,
  output logic [15:0]      imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [15:0]      imem_rdata,
  output logic [15:0]      instr,
  output logic [15:0]      pc_inc_2,
  output logic             instr_valid,
  output logic [15:0]      pc,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  fetch_state_e     state, state_nxt;
  logic [15:0]      pc_d, instr_d, pc_target;
  logic [CNT_W-1:0] retired_d;

  pc_next u_pc_next (
    .pc            (pc),
    .pc_src        (PCSrc),
    .branch_offset (branch_offset),
    .pc_inc_2      (pc_inc_2),
    .pc_nxt        (pc_target)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= REQ;
      pc      <= RESET_PC;
      instr   <= 16'h0000;
      retired <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_d;
      instr   <= instr_d;
      retired <= retired_d;
    end
  end

  // Next-state and datapath updates; decode inputs only matter in EXEC.
  always_comb begin
    state_nxt = state;
    pc_d      = pc;
    instr_d   = instr;
    retired_d = retired;
    case (state)
      REQ: begin
        if (imem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d   = imem_rdata;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        retired_d = retired + CNT_W'(1);
        if (hlt) begin
          state_nxt = HALT;
        end else begin
          pc_d      = pc_target;
          state_nxt = REQ;
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = REQ;
    endcase
  end

  // Request is masked while reset is held so the memory sees nothing then.
  assign imem_req    = rst_n & (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCSrc;
  logic [15:0] branch_offset;
  logic        hlt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] pc_inc_2;
  logic        instr_valid;
  logic [15:0] pc;
  logic        halted;
  logic [15:0] retired;

  fetch_stage #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCSrc         (PCSrc),
    .branch_offset (branch_offset),
    .hlt           (hlt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .pc_inc_2      (pc_inc_2),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .halted        (halted),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  // Memory contents and behaviour knobs (written by the main sequence only).
  logic [15:0] mem [0:32767];
  int ready_pct   = 100;
  int lat_max     = 0;
  int fixed_lat   = 0;
  int stall_total = 0;
  int stray_total = 0;

  // Memory model: accepts on the rising edge, drives outputs on the falling edge.
  bit          pend = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  int          lat_cnt = 0;
  int          stall_used = 0;
  int          stray_used = 0;

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (rst_n && imem_req && imem_ready) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        lat_cnt   = (fixed_lat >= 0) ? fixed_lat : $urandom_range(lat_max, 0);
      end
    end else if (!rst_n) begin
      pend        = 1'b0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0000;
    end else begin
      imem_rvalid = 1'b0;
      if (pend) begin
        if (lat_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[pend_addr[15:1]];
          pend        = 1'b0;
        end else begin
          lat_cnt--;
        end
      end else if (stray_used < stray_total) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        stray_used++;
      end
      if (stall_used < stall_total) begin
        imem_ready = 1'b0;
        stall_used++;
      end else begin
        imem_ready = ($urandom_range(99, 0) < ready_pct);
      end
    end
  end

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_pc;
  logic [15:0] exp_ret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: next PC is pc+2 plus twice the signed word offset, modulo 2^16.
  function automatic logic [15:0] branch_target(input logic [15:0] cur, input logic [15:0] off);
    int words;
    words = int'($signed(off));
    return 16'(int'(cur) + 2 + 2 * words);
  endfunction

  // Wait for the next presented instruction, check it, answer as decode would.
  task automatic step_exec(input logic take, input logic [15:0] off, input logic h);
    int waited = 0;
    while (!instr_valid && waited < 200) begin
      if (imem_req) check("req_addr_stable", 32'(imem_addr), 32'(exp_pc));
      @(posedge clk); #1;
      waited++;
    end
    check("exec_reached", 32'(instr_valid), 32'd1);
    if (instr_valid) begin
      check("instr", 32'(instr), 32'(mem[exp_pc[15:1]]));
      check("pc_exec", 32'(pc), 32'(exp_pc));
      check("pc_inc_2", 32'(pc_inc_2), 32'(16'(exp_pc + 16'd2)));
      check("retired_exec", 32'(retired), 32'(exp_ret));
      PCSrc         = take;
      branch_offset = off;
      hlt           = h;
      exp_ret       = exp_ret + 16'd1;
      if (!h) exp_pc = take ? branch_target(exp_pc, off) : 16'(exp_pc + 16'd2);
      @(posedge clk); #1;
      check("valid_one_cycle", 32'(instr_valid), 32'd0);
      check("halted_after", 32'(halted), 32'(h));
      check("req_after", 32'(imem_req), 32'(!h));
      check("pc_after", 32'(pc), 32'(exp_pc));
      check("retired_after", 32'(retired), 32'(exp_ret));
      // Decode lines carry junk outside EXEC; the stage must ignore them.
      PCSrc         = 1'($urandom);
      hlt           = 1'($urandom);
      branch_offset = 16'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  iv_bits;
    logic [8:0]  r9;

    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1123;
    mem[1] = 16'h2234;
    rst_n = 1'b0; PCSrc = 1'b0; hlt = 1'b0; branch_offset = 16'h0000;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_instr", 32'(instr), 32'h0000);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);

    // Cycle-exact first two instructions with a single-cycle memory.
    rst_n = 1'b1;
    #1;
    iv_bits = '0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      iv_bits[k] = instr_valid;
      if (k == 0) begin
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", 32'(imem_addr), 32'h0000);
      end
      if (k == 2) check("c2_instr", 32'(instr), 32'h1123);
      if (k == 3) begin
        check("c3_req", 32'(imem_req), 32'd1);
        check("c3_addr", 32'(imem_addr), 32'h0002);
      end
      if (k == 5) check("c5_instr", 32'(instr), 32'h2234);
    end
    check("valid_cycles", 32'(iv_bits), 32'(7'b0100100));
    check("retired_two", 32'(retired), 32'd2);
    exp_pc  = 16'h0004;
    exp_ret = 16'd2;

    // Branches, including the wrap cases.
    step_exec(1'b1, 16'h0005, 1'b0);
    check("reach_0010", 32'(imem_addr), 32'h0010);
    step_exec(1'b1, 16'hFFFC, 1'b0);
    check("br_back_000a", 32'(imem_addr), 32'h000A);
    step_exec(1'b1, 16'h0002, 1'b0);
    step_exec(1'b1, 16'h0003, 1'b0);
    check("br_fwd_0018", 32'(imem_addr), 32'h0018);
    step_exec(1'b1, 16'h7FF2, 1'b0);
    check("reach_fffe", 32'(imem_addr), 32'hFFFE);
    step_exec(1'b0, 16'($urandom), 1'b0);
    check("wrap_0000", 32'(imem_addr), 32'h0000);
    step_exec(1'b0, 16'($urandom), 1'b0);
    step_exec(1'b1, 16'h7FFF, 1'b0);
    check("br_wrap_0002", 32'(imem_addr), 32'h0002);

    // Ready held low 4 cycles, response 5 cycles late, stray rvalid in REQ.
    stall_total += 4;
    stray_total += 2;
    fixed_lat = 5;
    step_exec(1'b0, 16'h0000, 1'b0);
    // Stray rvalid in the same cycle the request is accepted.
    stray_total += 1;
    fixed_lat = 0;
    step_exec(1'b0, 16'h0000, 1'b0);

    // Random memory timing and random decode decisions.
    ready_pct = 70;
    lat_max   = 3;
    fixed_lat = -1;
    for (int n = 0; n < 40; n++) begin
      r9 = 9'($urandom);
      step_exec(1'($urandom), {{7{r9[8]}}, r9}, 1'b0);
    end

    // Reset while a response is outstanding.
    ready_pct = 100;
    fixed_lat = 10;
    step_exec(1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    check("wait_no_req", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rw_valid", 32'(instr_valid), 32'd0);
    check("rw_retired", 32'(retired), 32'd0);
    check("rw_pc", 32'(pc), 32'h0000);
    check("rw_req_low", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    fixed_lat = 0;
    #1;
    check("rw_req_first", 32'(imem_req), 32'd1);
    check("rw_addr_first", 32'(imem_addr), 32'h0000);
    exp_pc  = 16'h0000;
    exp_ret = 16'd0;
    step_exec(1'b0, 16'h0000, 1'b0);
    step_exec(1'b1, 16'h0010, 1'b0);

    // HLT together with PCSrc: halts, pc frozen, no further requests.
    step_exec(1'b1, 16'h0040, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_no_req", 32'(imem_req), 32'd0);
      check("halt_no_valid", 32'(instr_valid), 32'd0);
      check("halt_pc", 32'(pc), 32'(exp_pc));
      PCSrc = 1'($urandom);
      hlt   = 1'($urandom);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("hr_halted", 32'(halted), 32'd0);
    check("hr_pc", 32'(pc), 32'h0000);
    check("hr_retired", 32'(retired), 32'd0);
    check("hr_instr", 32'(instr), 32'h0000);
    rst_n = 1'b1;
    #1;
    check("hr_req", 32'(imem_req), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
